// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl
// Runs the row-clear pass that follows a piece lock. The rows touched by the
// piece (lock_row_lo..lock_row_hi) are scanned bottom-up for full rows. Any
// surviving row is copied down over the cleared ones with a read/modify/write
// pass, and the vacated rows at the top are zero-filled. The renderer receives
// the clear_row / row_to_clear / num_rows_to_clear notification, and a
// saturating running line total is kept.
//
// Optional build macro: LINE_CLEAR_EARLY_EXIT_EN
//   When defined, the scan stops at the first empty row above the piece once
//   at least one row was cleared. The remaining rows are then zero-filled
//   directly instead of being read. The final board contents are the same in
//   both builds.
//
// RAM write strobe/address/data are decoded combinationally from the current
// state. The copy-down write must use rd_data in the same cycle it becomes
// valid. Every other output comes straight from a flop.

module line_clear_ctrl_chk #(
   parameter int BOARD_H = 20,
   parameter int ROW_AW  = 5
) (
   input logic              Clk,
   input logic              Reset_n,
   input logic              busy,
   input logic              done,
   input logic              rd_en,
   input logic [ROW_AW-1:0] rd_addr,
   input logic              wr_en,
   input logic [ROW_AW-1:0] wr_addr,
   input logic              clear_row,
   input logic [2:0]        num_rows_to_clear
);

   localparam logic [ROW_AW:0] BOARD_H_EXT = (ROW_AW+1)'(BOARD_H);

   a_done_not_busy : assert property (@(posedge Clk) disable iff (!Reset_n)
      !(busy && done));

   a_no_rdwr_same_row : assert property (@(posedge Clk) disable iff (!Reset_n)
      !(rd_en && wr_en && (rd_addr == wr_addr)));

   a_rd_only_busy : assert property (@(posedge Clk) disable iff (!Reset_n)
      rd_en |-> busy);

   a_wr_only_busy : assert property (@(posedge Clk) disable iff (!Reset_n)
      wr_en |-> busy);

   a_rd_in_range : assert property (@(posedge Clk) disable iff (!Reset_n)
      rd_en |-> ({1'b0, rd_addr} < BOARD_H_EXT));

   a_wr_in_range : assert property (@(posedge Clk) disable iff (!Reset_n)
      wr_en |-> ({1'b0, wr_addr} < BOARD_H_EXT));

   a_clear_with_done : assert property (@(posedge Clk) disable iff (!Reset_n)
      clear_row |-> done);

   a_clear_count_range : assert property (@(posedge Clk) disable iff (!Reset_n)
      clear_row |-> ((num_rows_to_clear >= 3'd1) && (num_rows_to_clear <= 3'd4)));

endmodule

module line_clear_ctrl #(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20,
   parameter int ROW_AW  = 5
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               lock_valid,
   input  logic [ROW_AW-1:0]  lock_row_lo,
   input  logic [ROW_AW-1:0]  lock_row_hi,
   output logic               busy,
   output logic               done,
   output logic               rd_en,
   output logic [ROW_AW-1:0]  rd_addr,
   input  logic [BOARD_W-1:0] rd_data,
   output logic               wr_en,
   output logic [ROW_AW-1:0]  wr_addr,
   output logic [BOARD_W-1:0] wr_data,
   output logic               clear_row,
   output logic [ROW_AW-1:0]  row_to_clear,
   output logic [2:0]         num_rows_to_clear,
   output logic [15:0]        lines_total
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_CHK  = 3'd2;
   localparam logic [2:0] ST_FILL = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   // Widened by one bit so a board that exactly fills the address space
   // still compares correctly.
   localparam logic [ROW_AW:0] BOARD_H_EXT = (ROW_AW+1)'(BOARD_H);

   // A request is usable when lo <= hi, hi is on the board and the span is
   // at most four rows (the tallest piece).
   function automatic logic req_ok(input logic [ROW_AW-1:0] lo,
                                   input logic [ROW_AW-1:0] hi);
      logic ok;
      if (lo > hi) begin
         ok = 1'b0;
      end else if ({1'b0, hi} >= BOARD_H_EXT) begin
         ok = 1'b0;
      end else if ((hi - lo) > ROW_AW'(3)) begin
         ok = 1'b0;
      end else begin
         ok = 1'b1;
      end
      return ok;
   endfunction

   // The line counter sticks at its maximum instead of wrapping.
   function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                             input logic [2:0]  b);
      logic [16:0] sum;
      logic [15:0] res;
      sum = {1'b0, a} + {14'd0, b};
      if (sum[16]) begin
         res = 16'hFFFF;
      end else begin
         res = sum[15:0];
      end
      return res;
   endfunction

   // A row counts as full only when every cell is set.
   function automatic logic row_is_full(input logic [BOARD_W-1:0] row);
      return &row;
   endfunction

   // Pass state
   logic [2:0]         state_q, state_d;
   logic [ROW_AW-1:0]  src_q, src_d;        // row being scanned
   logic [ROW_AW-1:0]  dst_q, dst_d;        // next row to be written
   logic [ROW_AW-1:0]  lo_q, lo_d;          // top of the piece span
   logic [2:0]         shift_q, shift_d;    // full rows found so far
   logic [ROW_AW-1:0]  lowest_q, lowest_d;  // first (lowest) full row

   // Registered outputs
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               rd_en_q, rd_en_d;
   logic [ROW_AW-1:0]  rd_addr_q, rd_addr_d;
   logic               clear_row_q, clear_row_d;
   logic [ROW_AW-1:0]  row_to_clear_q, row_to_clear_d;
   logic [2:0]         num_q, num_d;
   logic [15:0]        lines_total_q, lines_total_d;

   // Combinational RAM write decode and scan helpers
   logic               row_full_s;
   logic               early_exit_s;
   logic               wr_en_s;
   logic [ROW_AW-1:0]  wr_addr_s;
   logic [BOARD_W-1:0] wr_data_s;

   // Next-state, scan bookkeeping and RAM-write decode for the clear pass
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      lo_d         = lo_q;
      shift_d      = shift_q;
      lowest_d     = lowest_q;
      row_full_s   = 1'b0;
      early_exit_s = 1'b0;
      wr_en_s      = 1'b0;
      wr_addr_s    = '0;
      wr_data_s    = '0;

      case (state_q)
         ST_IDLE: begin
            if (lock_valid) begin
               if (req_ok(lock_row_lo, lock_row_hi)) begin
                  src_d    = lock_row_hi;
                  dst_d    = lock_row_hi;
                  lo_d     = lock_row_lo;
                  shift_d  = 3'd0;
                  lowest_d = '0;
                  state_d  = ST_RD;
               end else begin
                  // Rejected request: finish at once with nothing cleared.
                  shift_d  = 3'd0;
                  state_d  = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RD: begin
            state_d = ST_CHK;
         end

         ST_CHK: begin
            // Rows above the piece can never be cleared by this lock.
            row_full_s = row_is_full(rd_data) && (src_q >= lo_q);
            if (row_full_s) begin
               shift_d = shift_q + 3'd1;
               if (shift_q == 3'd0) begin
                  lowest_d = src_q;
               end else begin
                  lowest_d = lowest_q;
               end
            end else begin
               if (shift_q != 3'd0) begin
                  // Surviving row drops down over the cleared rows.
                  wr_en_s   = 1'b1;
                  wr_addr_s = dst_q;
                  wr_data_s = rd_data;
               end else begin
                  // Nothing cleared yet: the row is already in place.
                  wr_en_s   = 1'b0;
               end
               dst_d = dst_q - ROW_AW'(1);
            end

`ifdef LINE_CLEAR_EARLY_EXIT_EN
            // Above the piece, an empty row means everything further up
            // is empty too, so the rest is a plain zero-fill.
            early_exit_s = !row_full_s && (shift_q != 3'd0) && (src_q < lo_q)
                           && (rd_data == '0);
`else
            early_exit_s = 1'b0;
`endif

            if ((src_q == lo_q) && (shift_d == 3'd0)) begin
               state_d = ST_DONE;
            end else if (early_exit_s) begin
               if (dst_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FILL;
               end
            end else if ((src_q == '0) && (shift_d != 3'd0)) begin
               state_d = ST_FILL;
            end else begin
               src_d   = src_q - ROW_AW'(1);
               state_d = ST_RD;
            end
         end

         ST_FILL: begin
            wr_en_s   = 1'b1;
            wr_addr_s = dst_q;
            wr_data_s = '0;
            if (dst_q == '0) begin
               state_d = ST_DONE;
            end else begin
               dst_d   = dst_q - ROW_AW'(1);
               state_d = ST_FILL;
            end
         end

         ST_DONE: begin
            shift_d = 3'd0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output values for the state being entered, so each output is a flop
   always_comb begin
      busy_d  = (state_d == ST_RD) || (state_d == ST_CHK) || (state_d == ST_FILL);
      done_d  = (state_d == ST_DONE);
      rd_en_d = (state_d == ST_RD);
      if (rd_en_d) begin
         rd_addr_d = src_d;
      end else begin
         rd_addr_d = '0;
      end
      clear_row_d = done_d && (shift_d != 3'd0);
      if (clear_row_d) begin
         row_to_clear_d = lowest_d;
         num_d          = shift_d;
         lines_total_d  = sat_add16(lines_total_q, shift_d);
      end else begin
         row_to_clear_d = '0;
         num_d          = 3'd0;
         lines_total_d  = lines_total_q;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q        <= ST_IDLE;
         src_q          <= '0;
         dst_q          <= '0;
         lo_q           <= '0;
         shift_q        <= 3'd0;
         lowest_q       <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         rd_en_q        <= 1'b0;
         rd_addr_q      <= '0;
         clear_row_q    <= 1'b0;
         row_to_clear_q <= '0;
         num_q          <= 3'd0;
         lines_total_q  <= 16'd0;
      end else begin
         state_q        <= state_d;
         src_q          <= src_d;
         dst_q          <= dst_d;
         lo_q           <= lo_d;
         shift_q        <= shift_d;
         lowest_q       <= lowest_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         rd_en_q        <= rd_en_d;
         rd_addr_q      <= rd_addr_d;
         clear_row_q    <= clear_row_d;
         row_to_clear_q <= row_to_clear_d;
         num_q          <= num_d;
         lines_total_q  <= lines_total_d;
      end
   end

   assign busy              = busy_q;
   assign done              = done_q;
   assign rd_en             = rd_en_q;
   assign rd_addr           = rd_addr_q;
   assign wr_en             = wr_en_s;
   assign wr_addr           = wr_addr_s;
   assign wr_data           = wr_data_s;
   assign clear_row         = clear_row_q;
   assign row_to_clear      = row_to_clear_q;
   assign num_rows_to_clear = num_q;
   assign lines_total       = lines_total_q;

   line_clear_ctrl_chk #(
      .BOARD_H (BOARD_H),
      .ROW_AW  (ROW_AW)
   ) u_chk (
      .Clk               (Clk),
      .Reset_n           (Reset_n),
      .busy              (busy),
      .done              (done),
      .rd_en             (rd_en),
      .rd_addr           (rd_addr),
      .wr_en             (wr_en),
      .wr_addr           (wr_addr),
      .clear_row         (clear_row),
      .num_rows_to_clear (num_rows_to_clear)
   );

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Testbench for line_clear_ctrl: a behavioural board RAM and a scoreboard.
// Each lock request pushes its expected outcome, which is taken from a
// simple compaction model of the board. The outcome is popped and compared
// when done pulses.
module tb_line_clear_ctrl;

   localparam int W  = 10;
   localparam int H  = 20;
   localparam int AW = 5;

   logic          Clk = 1'b0;
   logic          Reset_n;
   logic          lock_valid;
   logic [AW-1:0] lock_row_lo;
   logic [AW-1:0] lock_row_hi;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data = '0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic          clear_row;
   logic [AW-1:0] row_to_clear;
   logic [2:0]    num_rows_to_clear;
   logic [15:0]   lines_total;

   typedef struct {
      logic          clr;
      logic [4:0]    row;
      logic [2:0]    num;
      logic [15:0]   total;
      int            lat;
      int            nrd;
      int            nwr;
      int            start;
      int            rd0;
      int            wr0;
      logic [H*W-1:0] ram;
   } exp_t;

   exp_t        exp_q[$];
   logic [W-1:0] mem [H];
   logic [W-1:0] load_img [H];
   logic        load_req = 1'b0;
   logic [15:0] exp_total = 16'd0;
   int          cyc  = 0;
   int          n_rd = 0;
   int          n_wr = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   line_clear_ctrl #(.BOARD_W(W), .BOARD_H(H), .ROW_AW(AW)) dut (
      .Clk               (Clk),
      .Reset_n           (Reset_n),
      .lock_valid        (lock_valid),
      .lock_row_lo       (lock_row_lo),
      .lock_row_hi       (lock_row_hi),
      .busy              (busy),
      .done              (done),
      .rd_en             (rd_en),
      .rd_addr           (rd_addr),
      .rd_data           (rd_data),
      .wr_en             (wr_en),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .clear_row         (clear_row),
      .row_to_clear      (row_to_clear),
      .num_rows_to_clear (num_rows_to_clear),
      .lines_total       (lines_total)
   );

   always #5 Clk = ~Clk;

   // Board RAM: one-cycle read latency, plus access counters and preload
   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (rd_en) begin
         rd_data <= (rd_addr < AW'(H)) ? mem[rd_addr] : '0;
         n_rd    <= n_rd + 1;
      end
      if (load_req) begin
         for (int r = 0; r < H; r++) mem[r] <= load_img[r];
      end else if (wr_en) begin
         if (wr_addr < AW'(H)) mem[wr_addr] <= wr_data;
         n_wr <= n_wr + 1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expv, $time);
      end
   endtask

   // Scoreboard monitor: per-cycle sanity and outcome check at every done
   always @(negedge Clk) begin
      exp_t e;
      if (Reset_n) begin
         check_val("rd_wr_same_row", {31'd0, rd_en && wr_en && (rd_addr == wr_addr)}, 32'd0);
         if (done) begin
            if (exp_q.size() == 0) begin
               check_val("done_with_empty_queue", {31'd0, done}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_val("clear_row", {31'd0, clear_row}, {31'd0, e.clr});
               check_val("row_to_clear", {27'd0, row_to_clear}, {27'd0, e.row});
               check_val("num_rows_to_clear", {29'd0, num_rows_to_clear}, {29'd0, e.num});
               check_val("lines_total", {16'd0, lines_total}, {16'd0, e.total});
               check_val("busy_at_done", {31'd0, busy}, 32'd0);
`ifndef LINE_CLEAR_EARLY_EXIT_EN
               check_val("latency", cyc - e.start, e.lat);
               check_val("reads", n_rd - e.rd0, e.nrd);
               check_val("writes", n_wr - e.wr0, e.nwr);
`endif
               for (int r = 0; r < H; r++)
                  check_val($sformatf("ram_row%0d", r), {22'd0, mem[r]}, {22'd0, e.ram[r*W +: W]});
            end
         end else begin
            check_val("clear_row_outside_done", {31'd0, clear_row}, 32'd0);
         end
      end
   end

   task automatic clear_img();
      for (int r = 0; r < H; r++) load_img[r] = '0;
   endtask

   task automatic pattern_img();
      for (int r = 0; r < H; r++) load_img[r] = (r < 16) ? W'(r + 1) : '0;
   endtask

   task automatic apply_load();
      @(negedge Clk);
      load_req = 1'b1;
      @(negedge Clk);
      load_req = 1'b0;
   endtask

   // Drive one lock request, push its expected outcome and wait for it.
   // pulse_at > 1 raises an extra lock_valid that many cycles after the
   // lock; the DUT must ignore it.
   task automatic do_lock(input int lo, input int hi, input int pulse_at);
      exp_t       e;
      int         shift, lowest, d, t;
      logic       valid;
      logic [W-1:0] img [H];
      @(negedge Clk);
      for (int r = 0; r < H; r++) img[r] = mem[r];
      valid  = (lo <= hi) && (hi < H) && (hi - lo <= 3);
      shift  = 0;
      lowest = 0;
      if (valid) begin
         for (int r = hi; r >= lo; r--) begin
            if (mem[r] == 10'h3FF) begin
               if (shift == 0) lowest = r;
               shift++;
            end
         end
         if (shift > 0) begin
            d = H - 1;
            for (int r = H - 1; r >= 0; r--) begin
               if (!((r >= lo) && (r <= hi) && (mem[r] == 10'h3FF))) begin
                  img[d] = mem[r];
                  d--;
               end
            end
            for (int r = d; r >= 0; r--) img[r] = '0;
         end
      end
      if (valid && shift > 0) begin
         e.lat = 2 * (hi + 1) + shift + 1; e.nrd = hi + 1; e.nwr = hi + 1;
      end else if (valid) begin
         e.lat = 2 * (hi - lo + 1) + 1;    e.nrd = hi - lo + 1; e.nwr = 0;
      end else begin
         e.lat = 1;                        e.nrd = 0; e.nwr = 0;
      end
      t = int'(exp_total) + shift;
      exp_total = (t > 65535) ? 16'hFFFF : 16'(t);
      e.clr   = (shift > 0);
      e.row   = (shift > 0) ? 5'(lowest) : 5'd0;
      e.num   = 3'(shift);
      e.total = exp_total;
      e.start = cyc;
      e.rd0   = n_rd;
      e.wr0   = n_wr;
      for (int r = 0; r < H; r++) e.ram[r*W +: W] = img[r];
      exp_q.push_back(e);
      lock_row_lo = 5'(lo);
      lock_row_hi = 5'(hi);
      lock_valid  = 1'b1;
      @(negedge Clk);
      lock_valid  = 1'b0;
      if (pulse_at > 1) begin
         repeat (pulse_at - 1) @(negedge Clk);
         lock_row_lo = 5'd0;
         lock_row_hi = 5'd0;
         lock_valid  = 1'b1;
         @(negedge Clk);
         lock_valid  = 1'b0;
      end
      for (int k = 0; k < 300; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge Clk);
      end
      check_val("done_timeout_pending", exp_q.size(), 32'd0);
      exp_q.delete();
      repeat (12) @(negedge Clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached without finishing");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n     = 1'b0;
      lock_valid  = 1'b0;
      lock_row_lo = '0;
      lock_row_hi = '0;
      clear_img();
      apply_load();
      repeat (2) @(negedge Clk);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_rd_en", {31'd0, rd_en}, 32'd0);
      check_val("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check_val("rst_clear_row", {31'd0, clear_row}, 32'd0);
      check_val("rst_lines_total", {16'd0, lines_total}, 32'd0);
      Reset_n = 1'b1;

      // Empty board: two reads, no writes, nothing cleared
      do_lock(18, 19, 0);

      // Row 19 full, row 18 = 0x001
      clear_img(); load_img[19] = 10'h3FF; load_img[18] = 10'h001;
      apply_load();
      do_lock(18, 19, 0);

      // Tetris: rows 16-19 full over a non-zero pattern
      pattern_img(); for (int r = 16; r < 20; r++) load_img[r] = 10'h3FF;
      apply_load();
      do_lock(16, 19, 0);

      // Rows 17 and 19 full with survivors in between
      pattern_img(); load_img[19] = 10'h3FF; load_img[18] = 10'h2AA;
      load_img[17] = 10'h3FF; load_img[16] = 10'h155;
      apply_load();
      do_lock(16, 19, 0);

      // lock_valid while busy is ignored
      clear_img(); load_img[19] = 10'h3FF; load_img[18] = 10'h001;
      apply_load();
      do_lock(18, 19, 3);

      // Rejected requests: lo>hi, hi off board, span too large
      do_lock(5, 2, 0);
      do_lock(20, 20, 0);
      do_lock(10, 14, 0);

      // lock_valid in the DONE cycle is dropped
      clear_img(); load_img[19] = 10'h3FF; load_img[18] = 10'h001;
      apply_load();
      do_lock(18, 19, 42);

      // Reset in the middle of the zero-fill
      pattern_img(); for (int r = 16; r < 20; r++) load_img[r] = 10'h3FF;
      apply_load();
      @(negedge Clk);
      lock_row_lo = 5'd16; lock_row_hi = 5'd19; lock_valid = 1'b1;
      @(negedge Clk);
      lock_valid = 1'b0;
      repeat (41) @(negedge Clk);
      check_val("mid_fill_busy", {31'd0, busy}, 32'd1);
      check_val("mid_fill_wr_en", {31'd0, wr_en}, 32'd1);
      Reset_n = 1'b0;
      @(negedge Clk);
      check_val("abort_busy", {31'd0, busy}, 32'd0);
      check_val("abort_wr_en", {31'd0, wr_en}, 32'd0);
      check_val("abort_done", {31'd0, done}, 32'd0);
      check_val("abort_lines_total", {16'd0, lines_total}, 32'd0);
      Reset_n   = 1'b1;
      exp_total = 16'd0;

      // A normal lock after the abort
      pattern_img(); for (int r = 16; r < 20; r++) load_img[r] = 10'h3FF;
      apply_load();
      do_lock(16, 19, 0);

      // Saturation: preload 0xFFFE, clear four more rows
      @(negedge Clk);
      force dut.lines_total_q = 16'hFFFE;
      @(negedge Clk);
      release dut.lines_total_q;
      @(negedge Clk);
      check_val("preload_total", {16'd0, lines_total}, 32'h0000FFFE);
      exp_total = 16'hFFFE;
      pattern_img(); for (int r = 16; r < 20; r++) load_img[r] = 10'h3FF;
      apply_load();
      do_lock(16, 19, 0);

      // Single full row at the very top, total stays saturated
      clear_img(); load_img[0] = 10'h3FF; load_img[19] = 10'h0F0;
      apply_load();
      do_lock(0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
